// File: rtl/csr_timer_pkg.sv
// rtl/csr_timer_pkg.sv - TCFG field positions, register offsets and masked-write helper for the timer bank
package csr_timer_pkg;

  localparam int TCFG_EN          = 0;
  localparam int TCFG_PERIODIC    = 1;
  localparam int TCFG_INITVAL_LSB = 2;
  localparam int TICLR_CLR        = 0;

  typedef enum logic [1:0] {
    REG_TCFG  = 2'd0,
    REG_TVAL  = 2'd1,
    REG_TICLR = 2'd2,
    REG_RSVD  = 2'd3
  } reg_off_e;

  function automatic logic [31:0] masked_write(input logic [31:0] old_v,
                                               input logic [31:0] wmask,
                                               input logic [31:0] wvalue);
    return (wmask & wvalue) | (~wmask & old_v);
  endfunction

endpackage

// File: rtl/csr_timer_bank_if.sv
// rtl/csr_timer_bank_if.sv - CSR port, halt input and interrupt outputs of the timer bank
interface csr_timer_bank_if #(
  parameter int NUM_TIMERS = 4
);
  logic                  csr_we;
  logic [13:0]           csr_num;
  logic [31:0]           csr_wmask;
  logic [31:0]           csr_wvalue;
  logic [31:0]           csr_rvalue;
  logic                  csr_hit;
  logic                  timer_halt;
  logic [NUM_TIMERS-1:0] timer_irq;
  logic                  any_irq;

  modport master (
    output csr_we, csr_num, csr_wmask, csr_wvalue, timer_halt,
    input  csr_rvalue, csr_hit, timer_irq, any_irq
  );

  modport slave (
    input  csr_we, csr_num, csr_wmask, csr_wvalue, timer_halt,
    output csr_rvalue, csr_hit, timer_irq, any_irq
  );
endinterface

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one down-counter: config, count, sticky pending and registered irq
module timer_channel
  import csr_timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_tick,
  input  logic        i_cfg_we,
  input  logic        i_clr,
  input  logic [31:0] i_wmask,
  input  logic [31:0] i_wvalue,
  output logic [31:0] o_cfg,
  output logic [31:0] o_cnt,
  output logic        o_irq
);

  logic [CNT_W-1:0] r_cfg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pending;
  logic             r_irq;

  logic [31:0]      w_cfg_new;
  logic [CNT_W-1:0] w_cfg_next;
  logic [CNT_W-1:0] w_reload_cur;
  logic [CNT_W-1:0] w_reload_new;
  logic             w_expire;

  assign w_cfg_new    = masked_write(32'(r_cfg), i_wmask, i_wvalue);
  assign w_cfg_next   = w_cfg_new[CNT_W-1:0];
  assign w_reload_cur = {r_cfg[CNT_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign w_reload_new = {w_cfg_next[CNT_W-1:TCFG_INITVAL_LSB], 2'b00};
  assign w_expire     = i_tick && r_cfg[TCFG_EN] && (r_cnt == '0);

  // A config write owns cnt/EN this cycle; an expiry still lands in pending.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cfg     <= '0;
      r_cnt     <= '1;
      r_pending <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (i_cfg_we) begin
        r_cfg <= w_cfg_next;
        if (w_cfg_next[TCFG_EN]) begin
          r_cnt <= w_reload_new;
        end
      end else if (w_expire) begin
        if (r_cfg[TCFG_PERIODIC]) begin
          r_cnt <= w_reload_cur;
        end else begin
          r_cnt          <= '1;
          r_cfg[TCFG_EN] <= 1'b0;
        end
      end else if (i_tick && r_cfg[TCFG_EN]) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_expire) begin
        r_pending <= 1'b1;
      end else if (i_clr) begin
        r_pending <= 1'b0;
      end
      r_irq <= r_pending;
    end
  end

  assign o_cfg = 32'(r_cfg);
  assign o_cnt = 32'(r_cnt);
  assign o_irq = r_irq;

endmodule

// File: rtl/csr_timer_bank.sv
// rtl/csr_timer_bank.sv - multi-channel CSR timer bank: address decode, shared prescaler, read mux
module csr_timer_bank
  import csr_timer_pkg::*;
#(
  parameter int          NUM_TIMERS = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRESC_W    = 8,
  parameter logic [13:0] CSR_BASE   = 14'h41
) (
  input logic             clk,
  input logic             resetn,
  csr_timer_bank_if.slave bus
);

  localparam logic [13:0] PRESC_OFF = 14'(4 * NUM_TIMERS);

  logic [13:0]           w_off;
  logic                  w_presc_we;
  logic                  w_tick;
  logic [PRESC_W-1:0]    w_presc_next;
  logic [PRESC_W-1:0]    r_presc;
  logic [PRESC_W-1:0]    r_presc_cnt;
  logic [NUM_TIMERS-1:0] w_irq;
  logic [31:0]           w_ch_cfg [NUM_TIMERS];
  logic [31:0]           w_ch_cnt [NUM_TIMERS];

  // Offsets below CSR_BASE wrap to large values and fall outside the window.
  assign w_off       = bus.csr_num - CSR_BASE;
  assign bus.csr_hit = (w_off <= PRESC_OFF);
  assign w_presc_we  = bus.csr_we && (w_off == PRESC_OFF);

  assign w_presc_next = (bus.csr_wmask[PRESC_W-1:0] & bus.csr_wvalue[PRESC_W-1:0])
                      | (~bus.csr_wmask[PRESC_W-1:0] & r_presc);
  assign w_tick       = (r_presc_cnt == r_presc) && !bus.timer_halt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_presc     <= '0;
      r_presc_cnt <= '0;
    end else if (w_presc_we) begin
      r_presc     <= w_presc_next;
      r_presc_cnt <= '0;
    end else if (!bus.timer_halt) begin
      if (r_presc_cnt == r_presc) begin
        r_presc_cnt <= '0;
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_TIMERS; g++) begin : g_ch
    localparam logic [13:0] CH_OFF = 14'(4 * g);
    logic w_cfg_we;
    logic w_clr;

    assign w_cfg_we = bus.csr_we && (w_off == CH_OFF + 14'(REG_TCFG));
    assign w_clr    = bus.csr_we && (w_off == CH_OFF + 14'(REG_TICLR))
                    && bus.csr_wmask[TICLR_CLR] && bus.csr_wvalue[TICLR_CLR];

    timer_channel #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .resetn   (resetn),
      .i_tick   (w_tick),
      .i_cfg_we (w_cfg_we),
      .i_clr    (w_clr),
      .i_wmask  (bus.csr_wmask),
      .i_wvalue (bus.csr_wvalue),
      .o_cfg    (w_ch_cfg[g]),
      .o_cnt    (w_ch_cnt[g]),
      .o_irq    (w_irq[g])
    );
  end

  always_comb begin
    bus.csr_rvalue = '0;
    if (w_off == PRESC_OFF) begin
      bus.csr_rvalue = 32'(r_presc);
    end
    for (int i = 0; i < NUM_TIMERS; i++) begin
      if (w_off[13:2] == 12'(i)) begin
        case (reg_off_e'(w_off[1:0]))
          REG_TCFG: bus.csr_rvalue = w_ch_cfg[i];
          REG_TVAL: bus.csr_rvalue = w_ch_cnt[i];
          default:  bus.csr_rvalue = '0;
        endcase
      end
    end
  end

  assign bus.timer_irq = w_irq;
  assign bus.any_irq   = |w_irq;

endmodule

// File: tb/tb_csr_timer_bank.sv
// tb/tb_csr_timer_bank.sv - directed and randomized checks of csr_timer_bank against a behavioural model
`timescale 1ns/1ps
module tb_csr_timer_bank;

  localparam int          NT      = 4;
  localparam int          CW      = 32;
  localparam int          PW      = 8;
  localparam logic [13:0] BASE    = 14'h41;
  localparam logic [13:0] PRESC_A = BASE + 14'(4 * NT);

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  bit   clk_en = 1'b1;

  always #5 if (clk_en) clk = ~clk;

  csr_timer_bank_if #(.NUM_TIMERS(NT)) bus ();

  csr_timer_bank #(
    .NUM_TIMERS (NT),
    .CNT_W      (CW),
    .PRESC_W    (PW),
    .CSR_BASE   (BASE)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: one field per architectural register.
  bit          m_en   [NT];
  bit          m_per  [NT];
  bit          m_pend [NT];
  bit          m_irq  [NT];
  logic [31:0] m_init [NT];
  logic [31:0] m_cnt  [NT];
  logic [31:0] m_presc;
  logic [31:0] m_pcnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < NT; i++) begin
      m_en[i] = 0; m_per[i] = 0; m_pend[i] = 0; m_irq[i] = 0;
      m_init[i] = 0; m_cnt[i] = 32'hFFFF_FFFF;
    end
    m_presc = 0;
    m_pcnt  = 0;
  endfunction

  function automatic logic [31:0] m_cfg(input int i);
    return (m_init[i] << 2) + (m_per[i] ? 32'd2 : 32'd0) + (m_en[i] ? 32'd1 : 32'd0);
  endfunction

  function automatic bit m_hit(input logic [13:0] num);
    int off = int'(num) - int'(BASE);
    return (off >= 0) && (off <= 4 * NT);
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] num);
    int off = int'(num) - int'(BASE);
    if (!m_hit(num)) return 0;
    if (off == 4 * NT) return m_presc;
    if (off % 4 == 0) return m_cfg(off / 4);
    if (off % 4 == 1) return m_cnt[off / 4];
    return 0;
  endfunction

  function automatic logic [31:0] m_irq_vec();
    logic [31:0] v = 0;
    for (int i = 0; i < NT; i++) v[i] = m_irq[i];
    return v;
  endfunction

  function automatic void m_clock(input bit we, input logic [13:0] num,
                                  input logic [31:0] mask, input logic [31:0] val, input bit halt);
    int          off  = int'(num) - int'(BASE);
    bit          tick = (m_pcnt == m_presc) && !halt;
    bit          expd;
    logic [31:0] nv;
    if (we && off == 4 * NT) begin
      m_presc = ((mask & val) | (~mask & m_presc)) & 32'hFF;
      m_pcnt  = 0;
    end else if (!halt) begin
      m_pcnt = (m_pcnt == m_presc) ? 0 : m_pcnt + 1;
    end
    for (int i = 0; i < NT; i++) begin
      expd     = tick && m_en[i] && (m_cnt[i] == 0);
      m_irq[i] = m_pend[i];
      if (expd) m_pend[i] = 1;
      else if (we && off == 4 * i + 2 && mask[0] && val[0]) m_pend[i] = 0;
      if (we && off == 4 * i) begin
        nv = (mask & val) | (~mask & m_cfg(i));
        m_en[i] = nv[0]; m_per[i] = nv[1]; m_init[i] = nv >> 2;
        if (m_en[i]) m_cnt[i] = m_init[i] * 4;
      end else if (expd) begin
        if (m_per[i]) m_cnt[i] = m_init[i] * 4;
        else begin m_cnt[i] = 32'hFFFF_FFFF; m_en[i] = 0; end
      end else if (tick && m_en[i]) begin
        m_cnt[i] = m_cnt[i] - 1;
      end
    end
  endfunction

  // One clock: drive at negedge, check pre-write read, advance model, check irqs after the edge.
  task automatic step(input bit we, input logic [13:0] num, input logic [31:0] mask,
                      input logic [31:0] val, input bit halt);
    @(negedge clk);
    bus.csr_we = we; bus.csr_num = num; bus.csr_wmask = mask;
    bus.csr_wvalue = val; bus.timer_halt = halt;
    #1;
    chk($sformatf("hit@%0h", num), 32'(bus.csr_hit), 32'(m_hit(num)));
    chk($sformatf("rd@%0h", num), bus.csr_rvalue, m_read(num));
    m_clock(we, num, mask, val, halt);
    @(posedge clk);
    #1;
    chk("timer_irq", 32'(bus.timer_irq), m_irq_vec());
    chk("any_irq", 32'(bus.any_irq), 32'(m_irq_vec() != 0));
  endtask

  task automatic idle(input int n, input bit halt);
    for (int k = 0; k < n; k++) step(0, BASE + 14'd1, 0, 0, halt);
  endtask

  task automatic peek(input string tag, input logic [13:0] num, input logic [31:0] exp);
    bus.csr_we = 0; bus.csr_num = num;
    #1;
    chk(tag, bus.csr_rvalue, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [13:0] a;
    logic [31:0] v, mk;
    bit          w;
    bus.csr_we = 0; bus.csr_num = 0; bus.csr_wmask = 0; bus.csr_wvalue = 0; bus.timer_halt = 0;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1;
    #1;
    peek("reset_tval0", BASE + 14'd1, 32'hFFFF_FFFF);
    chk("reset_any", 32'(bus.any_irq), 0);

    // One-shot, TPRESC=0, INITVAL=2
    step(1, BASE, 32'hFFFF_FFFF, 32'h9, 0);
    peek("os_tval_8", BASE + 14'd1, 32'd8);
    for (int k = 7; k >= 0; k--) begin
      step(0, BASE + 14'd1, 0, 0, 0);
      peek($sformatf("os_tval_%0d", k), BASE + 14'd1, 32'(k));
    end
    step(0, BASE + 14'd1, 0, 0, 0);
    peek("os_tval_after", BASE + 14'd1, 32'hFFFF_FFFF);
    peek("os_en_off", BASE, 32'h8);
    chk("os_irq_not_yet", 32'(bus.timer_irq[0]), 0);
    step(0, BASE + 14'd1, 0, 0, 0);
    chk("os_irq_set", 32'(bus.timer_irq[0]), 1);
    step(1, BASE + 14'd2, 32'h1, 32'h1, 0);
    step(0, BASE + 14'd2, 0, 0, 0);
    chk("os_irq_cleared", 32'(bus.timer_irq[0]), 0);

    // Periodic ch1, INITVAL=1 -> period 5; clear, then clear colliding with expiry
    step(1, BASE + 14'd4, 32'hFFFF_FFFF, 32'h7, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, BASE + 14'd5, 0, 0, 0);
      peek($sformatf("per_tval_%0d", k), BASE + 14'd5, 32'((9 - k) % 5));
    end
    step(1, BASE + 14'd6, 32'hFFFF_FFFF, 32'h1, 0);
    chk("per_irq_w6", 32'(bus.timer_irq[1]), 1);
    step(0, BASE + 14'd5, 0, 0, 0);
    chk("per_irq_w7", 32'(bus.timer_irq[1]), 0);
    idle(2, 0);
    step(1, BASE + 14'd6, 32'hFFFF_FFFF, 32'h1, 0);
    chk("per_irq_w10", 32'(bus.timer_irq[1]), 0);
    step(0, BASE + 14'd5, 0, 0, 0);
    chk("per_clr_vs_expiry", 32'(bus.timer_irq[1]), 1);

    // Masked write: only EN cleared, count frozen
    v = m_cnt[1];
    step(1, BASE + 14'd4, 32'h1, 32'h0, 0);
    peek("mask_cfg", BASE + 14'd4, 32'h6);
    peek("mask_cnt_hold", BASE + 14'd5, v);
    idle(3, 0);
    peek("mask_cnt_hold2", BASE + 14'd5, v);
    step(1, BASE + 14'd6, 32'h1, 32'h1, 0);

    // Prescaler TPRESC=3, ch2 INITVAL=1, then halt mid-count
    step(1, PRESC_A, 32'hFF, 32'h3, 0);
    step(1, BASE + 14'd8, 32'hFFFF_FFFF, 32'h5, 0);
    for (int k = 1; k <= 7; k++) step(0, BASE + 14'd9, 0, 0, 0);
    peek("presc_tval_2", BASE + 14'd9, 32'd2);
    for (int k = 0; k < 10; k++) begin
      step(0, BASE + 14'd9, 0, 0, 1);
      peek($sformatf("halt_%0d", k), BASE + 14'd9, 32'd2);
    end
    idle(20, 0);
    peek("presc_done", BASE + 14'd9, 32'hFFFF_FFFF);
    step(1, PRESC_A, 32'hFF, 32'h0, 0);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      a  = BASE - 14'd2 + 14'($urandom_range(0, 4 * NT + 4));
      w  = ($urandom_range(0, 2) == 0);
      mk = ($urandom_range(0, 3) != 0) ? 32'hFFFF_FFFF : $urandom;
      v  = (a == PRESC_A) ? 32'($urandom_range(0, 3)) : 32'($urandom_range(0, 15));
      step(w, a, mk, v, ($urandom_range(0, 7) == 0));
    end

    // Asynchronous reset with the clock stopped
    @(negedge clk);
    clk_en = 0;
    #2 resetn = 0;
    #1;
    for (int i = 0; i < NT; i++) begin
      peek($sformatf("areset_tval%0d", i), BASE + 14'(4 * i + 1), 32'hFFFF_FFFF);
      peek($sformatf("areset_cfg%0d", i), BASE + 14'(4 * i), 32'h0);
    end
    peek("areset_presc", PRESC_A, 32'h0);
    chk("areset_irq", 32'(bus.timer_irq), 0);
    chk("areset_any", 32'(bus.any_irq), 0);
    resetn = 1;
    m_reset();
    #1 clk_en = 1;
    idle(3, 0);
    step(1, BASE + 14'd12, 32'hFFFF_FFFF, 32'h3, 0);
    idle(8, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
